// File: rtl/f32_div.sv
// f32_div: iterative binary32 restoring divider (FTZ), round-to-nearest-even when F32_DIV_RNE_EN is defined, else truncate
module f32_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] p
);
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [24:0] rem_q, rem_d;
  logic [23:0] mb_q, mb_d;
  logic [26:0] q_q, q_d;
  logic signed [9:0] e_q, e_d, e_r;
  logic [4:0] cnt_q, cnt_d;
  logic sign_q, sign_d, dz_q, dz_d;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb, rnd_f;
  logic za, zb, ia, ib, na, nb, s, inv, ge, inc, rnd_c;
  logic [23:0] rem_sub;
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign fa = a_q[22:0];
  assign fb = b_q[22:0];
  assign za = ea == 8'h00;
  assign zb = eb == 8'h00;
  assign ia = ea == 8'hff && fa == '0;
  assign ib = eb == 8'hff && fb == '0;
  assign na = ea == 8'hff && fa != '0;
  assign nb = eb == 8'hff && fb != '0;
  assign s = a_q[31] ^ b_q[31];
  assign inv = na | nb | (za & zb) | (ia & ib);
  assign ge = rem_q >= {1'b0, mb_q};
  assign rem_sub = rem_q[23:0] - mb_q;
`ifdef F32_DIV_RNE_EN
  assign inc = q_q[2] & (q_q[3] | (|q_q[1:0]) | (rem_q != '0));
`else
  assign inc = 1'b0;
`endif
  assign {rnd_c, rnd_f} = {1'b0, q_q[25:3]} + {23'b0, inc};
  assign e_r = e_q + $signed({9'b0, rnd_c});
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    dz_d = dz_q;
    rem_d = rem_q;
    mb_d = mb_q;
    q_d = q_q;
    e_d = e_q;
    cnt_d = cnt_q;
    sign_d = sign_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = a;
        b_d = b;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d = s;
        rem_d = {2'b01, fa};
        mb_d = {1'b1, fb};
        e_d = $signed({2'b0, ea}) - $signed({2'b0, eb}) + 10'sd127;
        q_d = '0;
        cnt_d = '0;
        state_d = (na | nb | za | zb | ia | ib) ? DONE : DIVIDE;
        if (na | nb | za | zb | ia | ib) begin
          p_d = inv ? 32'h7fc00000 : (ia | zb) ? {s, 8'hff, 23'b0} : {s, 31'b0};
          dz_d = !inv && !ia && zb;
        end
      end
      DIVIDE: begin
        q_d = {q_q[25:0], ge};
        rem_d = {ge ? rem_sub : rem_q[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        state_d = cnt_q == 5'd26 ? NORM : DIVIDE;
      end
      NORM: begin
        q_d = q_q[26] ? q_q : q_q << 1;
        e_d = q_q[26] ? e_q : e_q - 10'sd1;
        state_d = ROUND;
      end
      ROUND: begin
        p_d = e_r >= 10'sd255 ? {sign_q, 8'hff, 23'b0} :
              e_r <= 10'sd0   ? {sign_q, 31'b0} : {sign_q, e_r[7:0], rnd_f};
        dz_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      dz_q <= 1'b0;
      rem_q <= '0;
      mb_q <= '0;
      q_q <= '0;
      e_q <= '0;
      cnt_q <= '0;
      sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
      dz_q <= dz_d;
      rem_q <= rem_d;
      mb_q <= mb_d;
      q_q <= q_d;
      e_q <= e_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign p = p_q;
  assign dz = dz_q;
endmodule
